// File: rtl/flipdot_sampler_pkg.sv
// Shared flipdot geometry defaults (same values as the window counter stage) and FSM state type.
package flipdot_sampler_pkg;

    localparam int FD_COLS  = 28;
    localparam int FD_ROWS  = 14;
    localparam int FD_H_OFF = 224;
    localparam int FD_V_OFF = 112;
    localparam int FD_PIX_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/flipdot_cell_sampler.sv
// Tracks X/Y position inside the capture window and latches one thresholded luma bit per cell centre.
// Shadow bit updates one cycle after the sampled pixel; no backpressure (free-running pixel stream).
module flipdot_cell_sampler
    import flipdot_sampler_pkg::*;
#(
    parameter int COLS  = FD_COLS,
    parameter int ROWS  = FD_ROWS,
    parameter int H_OFF = FD_H_OFF,
    parameter int V_OFF = FD_V_OFF,
    parameter int PIX_W = FD_PIX_W
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   activ_c,
    input  logic                   activ_rise,
    input  logic                   activ_fall,
    input  logic                   vs_rise,
    input  logic [PIX_W-1:0]       luma,
    input  logic [PIX_W-1:0]       thresh,
    output logic [ROWS*COLS-1:0]   shadow
);

    localparam logic [31:0] CW      = 32'(H_OFF / COLS);
    localparam logic [31:0] CH      = 32'(V_OFF / ROWS);
    localparam logic [31:0] CW_HALF = CW / 32'd2;
    localparam logic [31:0] CH_HALF = CH / 32'd2;
    localparam logic [31:0] COLS_U  = 32'(COLS);
    localparam logic [31:0] ROWS_U  = 32'(ROWS);
    localparam logic [31:0] H_OFF_U = 32'(H_OFF);
    localparam logic [31:0] V_OFF_U = 32'(V_OFF);
    localparam int          IW      = $clog2(ROWS * COLS);

    logic [31:0]   x_loc;
    logic [31:0]   y_loc;
    logic [31:0]   x_cur;
    logic [31:0]   col;
    logic [31:0]   row;
    logic          hit;
    logic [IW-1:0] widx;

    // x_cur is the pixel index on this line, already zero on the first active pixel
    always_comb begin
        x_cur = activ_rise ? 32'd0 : x_loc;
        col   = x_cur / CW;
        row   = y_loc / CH;
        hit   = activ_c
              && ((x_cur % CW) == CW_HALF)
              && ((y_loc % CH) == CH_HALF)
              && (col < COLS_U)
              && (row < ROWS_U);
        widx  = IW'(row * COLS_U + col);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            x_loc  <= '0;
            y_loc  <= '0;
            shadow <= '0;
        end else begin
            // counters stop at the window edge so an overlong line never aliases onto column 0
            if (activ_c)
                x_loc <= (x_cur < H_OFF_U) ? x_cur + 32'd1 : x_cur;
            if (vs_rise)
                y_loc <= '0;
            else if (activ_fall && (y_loc < V_OFF_U))
                y_loc <= y_loc + 32'd1;
            if (hit)
                shadow[widx] <= (luma >= thresh);
        end
    end

endmodule

// File: rtl/flipdot_sampler.sv
// Samples video into a flipdot dot map and streams it out one row word per handshake.
// Rows start the cycle after VS rises; ROW_READY low stalls with row held; VS during SEND drops the frame.
module flipdot_sampler
    import flipdot_sampler_pkg::*;
#(
    parameter int COLS  = FD_COLS,
    parameter int ROWS  = FD_ROWS,
    parameter int H_OFF = FD_H_OFF,
    parameter int V_OFF = FD_V_OFF,
    parameter int PIX_W = FD_PIX_W
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             VS,
    input  logic             ACTIV_C,
    input  logic [PIX_W-1:0] LUMA,
    input  logic [PIX_W-1:0] THRESH,
    input  logic             ROW_READY,
    output logic             ROW_VALID,
    output logic [3:0]       ROW_IDX,
    output logic [COLS-1:0]  ROW_DATA,
    output logic             FRAME_DROP
);

    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

    fsm_state_t                        state;
    fsm_state_t                        state_nxt;
    logic [3:0]                        ptr;
    logic [3:0]                        ptr_nxt;
    logic                              load_buf;
    logic                              drop_nxt;
    logic                              vs_q;
    logic                              activ_q;
    logic                              vs_rise;
    logic                              activ_rise;
    logic                              activ_fall;
    logic [ROWS*COLS-1:0]              shadow;
    logic [ROWS-1:0][COLS-1:0]         out_buf;

    assign vs_rise    = VS & ~vs_q;
    assign activ_rise = ACTIV_C & ~activ_q;
    assign activ_fall = ~ACTIV_C & activ_q;

    flipdot_cell_sampler #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .H_OFF (H_OFF),
        .V_OFF (V_OFF),
        .PIX_W (PIX_W)
    ) u_cell_sampler (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .activ_c    (ACTIV_C),
        .activ_rise (activ_rise),
        .activ_fall (activ_fall),
        .vs_rise    (vs_rise),
        .luma       (LUMA),
        .thresh     (THRESH),
        .shadow     (shadow)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        load_buf  = 1'b0;
        drop_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (vs_rise) begin
                    load_buf  = 1'b1;
                    ptr_nxt   = '0;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                // a new frame arriving mid-transfer is discarded; the buffer keeps the frame being sent
                drop_nxt = vs_rise;
                if (ROW_READY) begin
                    if (ptr == LAST_ROW) begin
                        ptr_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        ptr_nxt = ptr + 4'd1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ptr        <= '0;
            vs_q       <= 1'b0;
            activ_q    <= 1'b0;
            FRAME_DROP <= 1'b0;
            out_buf    <= '0;
        end else begin
            ptr        <= ptr_nxt;
            vs_q       <= VS;
            activ_q    <= ACTIV_C;
            FRAME_DROP <= drop_nxt;
            if (load_buf)
                out_buf <= shadow;
        end
    end

    assign ROW_VALID = (state == ST_SEND);
    assign ROW_IDX   = ptr;
    assign ROW_DATA  = (state == ST_SEND) ? out_buf[ptr] : '0;

endmodule

// File: doc/flipdot_sampler.md
FLIPDOT_SAMPLER -- requirements
Module: flipdot_sampler

Interface
REQ-001 SHALL have parameter COLS, default 28: flipdot columns.
REQ-002 SHALL have parameter ROWS, default 14: flipdot rows.
REQ-003 SHALL have parameter H_OFF, default 224: active capture window width in pixels.
REQ-004 SHALL have parameter V_OFF, default 112: active capture window height in lines.
REQ-005 SHALL have parameter PIX_W, default 8: luma width.
REQ-006 SHALL have port CLK, input, 1: pixel clock; the only clock.
REQ-007 SHALL have port RESET_N, input, 1: reset, synchronous, active-low.
REQ-008 SHALL have port VS, input, 1: vertical sync; rising edge marks frame start.
REQ-009 SHALL have port ACTIV_C, input, 1: pixel lies inside the capture window (from window counter stage).
REQ-010 SHALL have port LUMA, input, PIX_W: pixel luma, aligned with ACTIV_C.
REQ-011 SHALL have port THRESH, input, PIX_W: dot-set threshold.
REQ-012 SHALL have port ROW_READY, input, 1: downstream dot driver accepts a row.
REQ-013 SHALL have port ROW_VALID, output, 1: row word valid.
REQ-014 SHALL have port ROW_IDX, output, 4: row number 0..ROWS-1.
REQ-015 SHALL have port ROW_DATA, output, COLS: dot states; bit c = column c; 1 = set (yellow).
REQ-016 SHALL have port FRAME_DROP, output, 1: one-cycle pulse when a completed frame is discarded.

Function
REQ-017 SHALL derive cell size CW = H_OFF/COLS and CH = V_OFF/ROWS (integer division; remainder pixels/lines ignored).
REQ-018 SHALL count X_LOC = pixels since ACTIV_C rose on the current line, cleared on each ACTIV_C rising edge, incremented each cycle ACTIV_C=1.
REQ-019 SHALL count Y_LOC = completed window lines, incremented on each ACTIV_C falling edge, cleared on VS rising edge, saturating at V_OFF.
REQ-020 SHALL sample cell (r,c) when X_LOC = c*CW + CW/2 and Y_LOC = r*CH + CH/2 with ACTIV_C=1, writing bit (LUMA >= THRESH) to shadow buffer [r][c]; CW/2 and CH/2 round down.
REQ-021 SHALL ignore samples with c >= COLS or r >= ROWS (no buffer write, no wrap).
REQ-022 SHALL hold state machine IDLE -> SEND -> IDLE.
REQ-023 SHALL, on VS rising edge in IDLE, copy shadow buffer to output buffer in the same cycle, set row pointer 0, and enter SEND the next cycle.
REQ-024 SHALL, on VS rising edge in SEND, leave output buffer unchanged and pulse FRAME_DROP for exactly one cycle.
REQ-025 SHALL, in SEND, drive ROW_VALID=1, ROW_IDX=pointer, ROW_DATA=output buffer[pointer]; ROW_IDX/ROW_DATA SHALL hold stable while ROW_VALID=1 and ROW_READY=0.
REQ-026 SHALL advance pointer on ROW_VALID & ROW_READY; transfer of row ROWS-1 SHALL return to IDLE with ROW_VALID=0 the next cycle.
REQ-027 SHALL NOT clear the shadow buffer at frame start; unsampled cells keep the previous frame's value.
REQ-028 SHALL support ROW_READY held high: one row per cycle, ROWS cycles per frame.

Reset
REQ-029 SHALL, while RESET_N=0 at a CLK edge, set state IDLE, ROW_VALID=0, ROW_IDX=0, ROW_DATA=0, FRAME_DROP=0, X_LOC=0, Y_LOC=0, both buffers to all zeros, edge-detect registers to 0.
REQ-030 SHALL, on reset asserted mid-SEND, abort the frame with no further rows; first VS rising edge after release starts a new frame normally.

Structure
REQ-031 SHALL take COLS, ROWS, H_OFF, V_OFF defaults from the shared flipdot parameter include used by the window counter stage.
REQ-032 SHALL place shadow-buffer sampling in one sub-module, flipdot_cell_sampler; edge detection, output buffer and FSM stay in the top.

Verification (COLS=28, ROWS=14, H_OFF=224, V_OFF=112, THRESH=128)
REQ-033 SHALL cover uniform LUMA=200 frame, ROW_READY=1 -> 14 rows, ROW_IDX 0..13 consecutive cycles, every ROW_DATA = 28'hFFFFFFF.
REQ-034 SHALL cover checkerboard on 8x8 cells (cell white when r+c even), LUMA 255/0 -> row 0 = 28'h5555555, row 1 = 28'hAAAAAAA.
REQ-035 SHALL cover ROW_READY toggling 1 cycle high / 3 low -> ROW_DATA/ROW_IDX stable while stalled, all 14 rows delivered once, in order.
REQ-036 SHALL cover second VS rising edge while ROW_READY=0 in SEND -> FRAME_DROP high exactly one cycle, output rows still from frame 1.
REQ-037 SHALL cover LUMA exactly 128 at sample point (4,4) only, else 0 -> only row 0 bit 0 = 1 (>= rule).
REQ-038 SHALL cover RESET_N low for 1 cycle during row 5 transfer -> ROW_VALID=0 next cycle, all outputs zero, next frame starts at ROW_IDX 0.
